pipe_mux_n: RTL

- Parametrised N:1 word selector with a registered ready/valid pipeline stage. Next generation of the combinational operand-select muxes.
- Selects one of NUM_IN words of WIDTH bits and carries the result through a 2-entry skid stage, so that forwarding and writeback select paths can be pipelined.
- Supports back-pressure (stall) and flush from the hazard unit.

---
 rtl/pipe_mux_n.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipe_mux_n.sv
// N:1 word selector feeding a 2-entry (main + skid) ready/valid stage with flush.
// Optional out-of-range select flag enabled by defining PIPE_MUX_SEL_CHECK_EN.
module pipe_mux_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    sel_err
);

    // Handshake: a word moves on an edge where valid && ready are both high;
    // valid never waits on ready, and in_ready comes straight from a flop.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] s_data;
    logic [WIDTH-1:0] sel_word;
    logic             in_ready_q;
    logic             accept;
    logic             drain;
    logic             m_load_in;
    logic             m_load_s;
    logic             s_load;

    // Unmatched select values fall through to the all-zero default.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        m_load_in = 1'b0;
        m_load_s  = 1'b0;
        s_load    = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    m_load_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    m_load_in = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_FULL;
                    s_load    = 1'b1;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    state_nxt = ST_ONE;
                    m_load_s  = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush wins over any accept or drain in the same cycle.
        if (flush) begin
            state_nxt = ST_EMPTY;
            m_load_in = 1'b0;
            m_load_s  = 1'b0;
            s_load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            m_data     <= '0;
            s_data     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_FULL);
            if (m_load_in) begin
                m_data <= sel_word;
            end else if (m_load_s) begin
                m_data <= s_data;
            end
            if (s_load) begin
                s_data <= sel_word;
            end
        end
    end

    // Data registers may hold stale words after a flush or drain; mask them.
    assign out_data = out_valid ? m_data : '0;

`ifdef PIPE_MUX_SEL_CHECK_EN
    logic sel_err_q;
    logic sel_oor;

    assign sel_oor = ({1'b0, in_sel} >= (SEL_W+1)'(NUM_IN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (accept && sel_oor) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule
